seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle, parametrised double-width shifter for the ALU datapath.
- Takes a WIDTH-bit operand and produces a 2*WIDTH-bit result, split into res_high and res_low.
- Supports four modes: logical left, logical right, arithmetic right and rotate-left.
- Shifts iteratively, at most STEP bits per cycle, with a start/busy/done handshake so it fits the multi-cycle execute stage next to the multiplier.

Parameters:
- WIDTH, 32: operand width. Power of two, >= 4.
- STEP, 4: maximum bits shifted per cycle. Power of two, 1 <= STEP <= 2*WIDTH.
- SAW (localparam), clog2(2*WIDTH): shift-amount width; 6 for WIDTH=32.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- a  input  WIDTH  operand.
- b  input  WIDTH  shift amount; only b[SAW-1:0] is used.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result becomes valid.
- res_high  output  WIDTH  upper half of the 2*WIDTH result.
- res_low  output  WIDTH  lower half of the 2*WIDTH result.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, res_high=0, res_low=0.
  - Working register and remaining counter cleared.
  - No done pulse for the aborted operation.
- Shift amount at accept: amt = b[SAW-1:0] (range 0..2*WIDTH-1). For ROL, amt = b[SAW-1:0] mod WIDTH.
- Working register w (2*WIDTH bits), loaded at accept:
  - SLL: w = {0, a}.
  - SRL and SRA: w = {a, 0}.
  - ROL: w = {0, a}; only w[WIDTH-1:0] rotates.
- States:
  - IDLE: start=1 -> latch op, w and rem=amt; go to SHIFT. start=0 -> stay.
  - SHIFT: busy=1.
    - If rem > STEP: shift w by STEP, rem -= STEP, stay.
    - Else: shift w by rem, rem=0, copy the shifted w into res_high/res_low on this same edge, go to DONE.
    - amt=0 therefore still spends exactly one SHIFT cycle.
  - DONE: done=1 for exactly this cycle. start=1 -> accept a new operation (same as IDLE) and go to SHIFT. Otherwise -> IDLE.
- Per-cycle shift rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with w[2*WIDTH-1], i.e. the original a[WIDTH-1].
  - ROL: w[WIDTH-1:0] rotates left; w[2*WIDTH-1:WIDTH] stays 0.
- Latency: done is high in the cycle after 1 + max(1, ceil(amt/STEP)) rising edges, counting the accept edge.
- Result registers hold their value from DONE until the next result is written; they do not change during SHIFT.
- start in SHIFT is ignored; no queueing.
- op, a and b are sampled only at the accept edge; changes afterwards have no effect.
- Simultaneous events:
  - reset wins over everything.
  - start in DONE is accepted and the done pulse is still emitted in that cycle.
- Never more than one operation in flight; no back-pressure on done.

Test Plan (WIDTH=32, STEP=4):
- SLL a=0x80000001 b=1: done after 2 edges; res_high=0x00000001, res_low=0x00000002; busy high for exactly 1 cycle.
- SLL a=0xFFFFFFFF b=63: 16 SHIFT cycles, done after 17 edges; res_high=0x80000000, res_low=0x00000000.
- SRA a=0x80000000 b=4 -> res_high=0xF8000000, res_low=0. SRL a=0x0000000F b=4 -> res_high=0, res_low=0xF0000000.
- ROL a=0x80000001 b=33 (amt=1) -> res_low=0x00000003, res_high=0. SLL a=0x12345678 b=0x40 (amt=0) -> res_low=0x12345678, res_high=0, done after 2 edges.
- Pulse start with different a mid-SHIFT -> ignored, original result delivered. Then start held high across DONE -> back-to-back accept, done pulses on both results.
- Assert reset during SHIFT of a 63-bit shift -> outputs all 0 immediately (asynchronously), state IDLE, no done. A subsequent SLL a=1 b=5 -> res_low=0x20.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Iterative double-width shifter (SLL/SRL/SRA/ROL), up to STEP bits per cycle.
// Latency: done in the cycle after 1 + max(1, ceil(amt/STEP)) rising edges (accept edge included).
// Backpressure: none; start is taken only in IDLE/DONE, ignored while busy; done is a one-cycle pulse.
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_high,
    output logic [WIDTH-1:0] res_low
);

    localparam int SAW = $clog2(2 * WIDTH);
    // Counter is one bit wider than SAW so that STEP == 2*WIDTH is representable.
    localparam int CW  = $clog2(2 * WIDTH + 1);
    localparam int W2  = 2 * WIDTH;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W2-1:0]   w_q, w_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] res_high_q, res_high_d;
    logic [WIDTH-1:0] res_low_q, res_low_d;

    logic [CW-1:0]   step_amt;
    logic [W2-1:0]   w_shifted;
    logic [W2-1:0]   rot_dbl;
    logic            last_step;

    // Upper operand bits of b never affect the shift amount.
    logic            unused_b;
    assign unused_b = ^b[WIDTH-1:SAW];

    // The final step consumes whatever remains (possibly zero).
    assign last_step = (rem_q <= CW'(STEP));
    assign step_amt  = last_step ? rem_q : CW'(STEP);

    // One iteration of the selected shift applied to the working register.
    always_comb begin
        w_shifted = w_q;
        rot_dbl   = {w_q[WIDTH-1:0], w_q[WIDTH-1:0]} << step_amt;
        case (op_q)
            OP_SLL:  w_shifted = w_q << step_amt;
            OP_SRL:  w_shifted = w_q >> step_amt;
            OP_SRA:  w_shifted = $signed(w_q) >>> step_amt;
            default: w_shifted = {{WIDTH{1'b0}}, rot_dbl[W2-1:WIDTH]};
        endcase
    end

    // Next-state logic: accept, iterate, publish result.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        w_d        = w_q;
        rem_d      = rem_q;
        res_high_d = res_high_q;
        res_low_d  = res_low_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    state_d = S_SHIFT;
                    case (op)
                        OP_SRL, OP_SRA: w_d = {a, {WIDTH{1'b0}}};
                        default:        w_d = {{WIDTH{1'b0}}, a};
                    endcase
                    // Rotation only spans the low half, so its amount wraps at WIDTH.
                    if (op == OP_ROL) begin
                        rem_d = CW'(b[SAW-2:0]);
                    end else begin
                        rem_d = CW'(b[SAW-1:0]);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_d = w_shifted;
                if (last_step) begin
                    rem_d      = '0;
                    res_high_d = w_shifted[W2-1:WIDTH];
                    res_low_d  = w_shifted[WIDTH-1:0];
                    state_d    = S_DONE;
                end else begin
                    rem_d = rem_q - CW'(STEP);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_SLL;
            w_q        <= '0;
            rem_q      <= '0;
            res_high_q <= '0;
            res_low_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            w_q        <= w_d;
            rem_q      <= rem_d;
            res_high_q <= res_high_d;
            res_low_q  <= res_low_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign res_high = res_high_q;
    assign res_low  = res_low_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized bench for seq_shift_unit against an arithmetic reference model.
// Checks result, done latency, busy duration, result hold and reset abort.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_seq_shift_unit;

    localparam int W    = 32;
    localparam int STEP = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] res_high;
    logic [W-1:0] res_low;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [63:0]  exp_res  = '0;

    always #5 clock = ~clock;

    seq_shift_unit #(.WIDTH(W), .STEP(STEP)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .res_high (res_high),
        .res_low  (res_low)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Full-width result of the operation, straight from the mode definitions.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        int                 amt;
        int                 r;
        logic signed [63:0] s;
        logic [31:0]        rot;
        amt = int'(bv[5:0]);
        case (o)
            2'd0: model = {32'd0, av} << amt;
            2'd1: model = {av, 32'd0} >> amt;
            2'd2: begin
                s     = {av, 32'd0};
                model = s >>> amt;
            end
            default: begin
                r     = amt % 32;
                rot   = (r == 0) ? av : ((av << r) | (av >> (32 - r)));
                model = {32'd0, rot};
            end
        endcase
    endfunction

    function automatic int busy_cycles(input logic [1:0] o, input logic [31:0] bv);
        int amt;
        amt = int'(bv[5:0]);
        if (o == 2'd3) amt = amt % 32;
        return (amt == 0) ? 1 : (amt + STEP - 1) / STEP;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
    endtask

    // Follow one launched operation to its done pulse. Inputs are scrambled
    // after the accept edge; start is pulsed once at edge 'poke' (0 = never).
    task automatic run(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input int poke);
        int          edges;
        int          bcnt;
        int          eb;
        logic [63:0] exp_now;
        edges   = 0;
        bcnt    = 0;
        eb      = busy_cycles(o, bv);
        exp_now = model(o, av, bv);
        while (1) begin
            @(posedge clock);
            #1;
            edges++;
            if (done) break;
            if (busy) begin
                bcnt++;
                check_eq("hold", {res_high, res_low}, exp_res);
            end
            if (edges >= 100) break;
            start = (edges == poke);
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom_range(0, 3));
        end
        check_eq("done_edges", 64'(edges), 64'(eb + 1));
        check_eq("busy_cycles", 64'(bcnt), 64'(eb));
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        check_eq("result", {res_high, res_low}, exp_now);
        exp_res = exp_now;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
            check_eq("idle_ctl", {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] av;
        logic [31:0] bv;
        int          poke;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_res", {res_high, res_low}, 64'd0);
        check_eq("reset_ctl", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        idle(2);

        // Directed cases
        launch(2'd0, 32'h8000_0001, 32'd1);  run(2'd0, 32'h8000_0001, 32'd1, 0);  idle(1);
        launch(2'd0, 32'hFFFF_FFFF, 32'd63); run(2'd0, 32'hFFFF_FFFF, 32'd63, 0); idle(1);
        launch(2'd2, 32'h8000_0000, 32'd4);  run(2'd2, 32'h8000_0000, 32'd4, 0);  idle(1);
        launch(2'd1, 32'h0000_000F, 32'd4);  run(2'd1, 32'h0000_000F, 32'd4, 0);  idle(1);
        launch(2'd3, 32'h8000_0001, 32'd33); run(2'd3, 32'h8000_0001, 32'd33, 0); idle(1);
        launch(2'd0, 32'h1234_5678, 32'h40); run(2'd0, 32'h1234_5678, 32'h40, 0); idle(1);

        // start pulsed mid-shift, then back-to-back accepts from DONE
        launch(2'd0, 32'h1234_5678, 32'd63); run(2'd0, 32'h1234_5678, 32'd63, 5);
        launch(2'd3, 32'hDEAD_BEEF, 32'd13); run(2'd3, 32'hDEAD_BEEF, 32'd13, 0);
        launch(2'd2, 32'h9000_0000, 32'd37); run(2'd2, 32'h9000_0000, 32'd37, 2);
        idle(2);

        // Random operations with random gaps (gap 0 accepts from DONE)
        for (int i = 0; i < 40; i++) begin
            o    = 2'($urandom_range(0, 3));
            av   = $urandom;
            bv   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            poke = ($urandom_range(0, 3) == 0) ? 2 : 0;
            launch(o, av, bv);
            run(o, av, bv, poke);
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a long shift
        launch(2'd0, 32'h8000_0001, 32'd1); run(2'd0, 32'h8000_0001, 32'd1, 0);
        launch(2'd0, 32'hFFFF_FFFF, 32'd63);
        repeat (5) begin
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_res", {res_high, res_low}, 64'd0);
        check_eq("rst_async_ctl", {62'd0, busy, done}, 64'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            check_eq("rst_hold_ctl", {62'd0, busy, done}, 64'd0);
        end
        reset   = 1'b0;
        exp_res = '0;
        idle(20);
        check_eq("rst_res_after", {res_high, res_low}, 64'd0);
        launch(2'd0, 32'h0000_0001, 32'd5); run(2'd0, 32'h0000_0001, 32'd5, 0);
        check_eq("post_rst_low", {32'd0, res_low}, 64'h20);
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
